// File: rtl/hv_shot_sequencer_pkg.sv
// Shared definitions for the HV shot sequencer: state encoding and default tick rate.
// The host status readout decodes the same 3-bit state values.
package hvsq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHARGE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_FIRE   = 3'd3,
        ST_COOL   = 3'd4,
        ST_FAULT  = 3'd5
    } hvsq_state_e;

    localparam int HVSQ_CLK_HZ_DEFAULT = 100_000_000;

endpackage

// File: rtl/hv_shot_sequencer_if.sv
// Host/supply-side signal bundle of the HV shot sequencer.
// master = host and supply side, slave = the sequencer itself.
interface hv_shot_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             hvsq_start;
    logic             hvsq_abort;
    logic             hv_ready;
    logic [7:0]       hold_s;
    logic [7:0]       cool_s;
    logic             hv_en;
    logic             fire;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] shot_cnt;
    logic [2:0]       state;

    modport master (
        output hvsq_start, hvsq_abort, hv_ready, hold_s, cool_s,
        input  hv_en, fire, busy, fault, shot_cnt, state
    );

    modport slave (
        input  hvsq_start, hvsq_abort, hv_ready, hold_s, cool_s,
        output hv_en, fire, busy, fault, shot_cnt, state
    );
endinterface

// File: rtl/hv_shot_sequencer_sec_tick.sv
// One-second tick generator: prescaler restarts on clr so the first tick
// lands exactly CLK_HZ cycles after the sequencer enters a state.
module hvsq_sec_tick
    import hvsq_pkg::*;
#(
    parameter int CLK_HZ = HVSQ_CLK_HZ_DEFAULT
) (
    input  logic clk_hvsq,
    input  logic rst_hvsq,
    input  logic clr,
    output logic tick
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk_hvsq or posedge rst_hvsq) begin
        if (rst_hvsq) begin
            presc <= '0;
        end else if (clr || presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Decoded from the register only, so clr (derived from next state) cannot loop back.
    assign tick = (presc == PRESC_LAST);

endmodule

// File: rtl/hv_shot_sequencer.sv
// Supervised HV shot sequencer: charge, hold, fire, cooldown, with ready
// timeout, abort and a wrapping completed-shot counter.
module hv_shot_sequencer
    import hvsq_pkg::*;
#(
    parameter int CLK_HZ     = HVSQ_CLK_HZ_DEFAULT,
    parameter int FIRE_CYC   = 100,
    parameter int READY_TO_S = 5,
    parameter int CNT_W      = 16
) (
    input  logic               clk_hvsq,
    input  logic               rst_hvsq,
    hv_shot_sequencer_if.slave bus
);
    localparam int FW = (FIRE_CYC > 1) ? $clog2(FIRE_CYC) : 1;
    localparam logic [FW-1:0] FIRE_LAST = FW'(FIRE_CYC - 1);
    localparam logic [7:0]    READY_TO  = 8'(READY_TO_S);

    hvsq_state_e      state_q;
    hvsq_state_e      state_d;
    logic             ready_meta;
    logic             ready_sync;
    logic             sec_tick;
    logic             state_chg;
    logic [7:0]       sec_cnt;
    logic [7:0]       sec_cur;
    logic [7:0]       hold_cfg;
    logic [7:0]       cool_cfg;
    logic [FW-1:0]    fire_cnt;
    logic [CNT_W-1:0] shot_cnt_q;
    logic             hv_en_q;
    logic             fire_q;
    logic             busy_q;
    logic             fault_q;

    assign state_chg = (state_d != state_q);
    // Seconds including a tick firing this cycle, so an N-second wait ends after exactly N*CLK_HZ cycles.
    assign sec_cur   = sec_cnt + {7'd0, sec_tick};

    hvsq_sec_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk_hvsq (clk_hvsq),
        .rst_hvsq (rst_hvsq),
        .clr      (state_chg),
        .tick     (sec_tick)
    );

    always_ff @(posedge clk_hvsq or posedge rst_hvsq) begin
        if (rst_hvsq) begin
            ready_meta <= 1'b0;
            ready_sync <= 1'b0;
        end else begin
            ready_meta <= bus.hv_ready;
            ready_sync <= ready_meta;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != ST_IDLE && bus.hvsq_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.hvsq_start) state_d = ST_CHARGE;
                end
                ST_CHARGE: begin
                    if (ready_sync)              state_d = ST_HOLD;
                    else if (sec_cur == READY_TO) state_d = ST_FAULT;
                end
                ST_HOLD: begin
                    if (!ready_sync)              state_d = ST_FAULT;
                    else if (sec_cur == hold_cfg) state_d = ST_FIRE;
                end
                ST_FIRE: begin
                    if (fire_cnt == FIRE_LAST) state_d = ST_COOL;
                end
                ST_COOL: begin
                    if (sec_cur == cool_cfg) state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_hvsq or posedge rst_hvsq) begin
        if (rst_hvsq) begin
            state_q    <= ST_IDLE;
            sec_cnt    <= '0;
            fire_cnt   <= '0;
            hold_cfg   <= '0;
            cool_cfg   <= '0;
            shot_cnt_q <= '0;
        end else begin
            state_q <= state_d;

            if (state_chg)     sec_cnt <= '0;
            else if (sec_tick) sec_cnt <= sec_cnt + 8'd1;

            if (state_chg)                fire_cnt <= '0;
            else if (state_q == ST_FIRE)  fire_cnt <= fire_cnt + 1'b1;

            // Settings are frozen at launch so the running shot ignores later edits.
            if (state_q == ST_IDLE && state_d == ST_CHARGE) begin
                hold_cfg <= bus.hold_s;
                cool_cfg <= bus.cool_s;
            end

            if (state_q == ST_FIRE && state_d == ST_COOL) shot_cnt_q <= shot_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_hvsq or posedge rst_hvsq) begin
        if (rst_hvsq) begin
            hv_en_q <= 1'b0;
            fire_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            hv_en_q <= (state_d == ST_CHARGE) || (state_d == ST_HOLD) || (state_d == ST_FIRE);
            fire_q  <= (state_d == ST_FIRE);
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign bus.hv_en    = hv_en_q;
    assign bus.fire     = fire_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;
    assign bus.shot_cnt = shot_cnt_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_hv_shot_sequencer.sv
// Self-checking bench for hv_shot_sequencer: elapsed-time reference model,
// per-cycle output compare, directed scenarios plus a randomized phase.
module tb_hv_shot_sequencer;
    localparam int CLK_HZ     = 10;
    localparam int FIRE_CYC   = 4;
    localparam int READY_TO_S = 3;
    localparam int CNT_W      = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] hold = 8'd0;
    logic [7:0] cool = 8'd0;

    int checks = 0;
    int errors = 0;

    hv_shot_sequencer_if #(.CNT_W(CNT_W)) bus ();

    assign bus.hvsq_start = start;
    assign bus.hvsq_abort = abort;
    assign bus.hv_ready   = ready;
    assign bus.hold_s     = hold;
    assign bus.cool_s     = cool;

    hv_shot_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .FIRE_CYC   (FIRE_CYC),
        .READY_TO_S (READY_TO_S),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_hvsq (clk),
        .rst_hvsq (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus cycles elapsed in it; waits are N seconds = N*CLK_HZ cycles.
    int m_state = 0;
    int m_elapsed = 0;
    int m_shots = 0;
    int m_hold = 0;
    int m_cool = 0;
    int m_nxt = 0;
    bit m_r1 = 1'b0;
    bit m_rs = 1'b0;
    int last_len [6];

    function automatic bit secs_done(int elapsed, int secs);
        return (secs == 0) || (elapsed + 1 == secs * CLK_HZ);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_elapsed = 0; m_shots = 0;
            m_hold = 0; m_cool = 0; m_r1 = 1'b0; m_rs = 1'b0;
        end else begin
            m_nxt = m_state;
            if (m_state != 0 && abort) begin
                m_nxt = 0;
            end else begin
                case (m_state)
                    0: if (start) begin m_nxt = 1; m_hold = int'(hold); m_cool = int'(cool); end
                    1: if (m_rs) m_nxt = 2;
                       else if (m_elapsed + 1 == READY_TO_S * CLK_HZ) m_nxt = 5;
                    2: if (!m_rs) m_nxt = 5;
                       else if (secs_done(m_elapsed, m_hold)) m_nxt = 3;
                    3: if (m_elapsed + 1 == FIRE_CYC) begin
                           m_nxt = 4;
                           m_shots = (m_shots + 1) % (1 << CNT_W);
                       end
                    4: if (secs_done(m_elapsed, m_cool)) m_nxt = 0;
                    default: ;
                endcase
            end
            m_rs = m_r1;
            m_r1 = ready;
            if (m_nxt == m_state) begin
                m_elapsed++;
            end else begin
                last_len[m_state] = m_elapsed + 1;
                m_elapsed = 0;
            end
            m_state = m_nxt;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cyc_state", int'(bus.state), m_state);
        checkOutput("cyc_hv_en", int'(bus.hv_en), int'(m_state >= 1 && m_state <= 3));
        checkOutput("cyc_fire", int'(bus.fire), int'(m_state == 3));
        checkOutput("cyc_busy", int'(bus.busy), int'(m_state >= 1 && m_state <= 4));
        checkOutput("cyc_fault", int'(bus.fault), int'(m_state == 5));
        checkOutput("cyc_shot_cnt", int'(bus.shot_cnt), m_shots);
    end

    task automatic applyStimulus(input logic st, input logic ab, input logic rdy,
                                 input logic [7:0] hs, input logic [7:0] cs);
        @(negedge clk);
        start = st; abort = ab; ready = rdy; hold = hs; cool = cs;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitState(input int s, input int budget);
        int i = 0;
        while (m_state != s && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (m_state != s) checkOutput("wait_state_timeout", m_state, s);
    endtask

    task automatic waitShots(input int target, input int budget);
        int i = 0;
        while (m_shots != target && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (m_shots != target) checkOutput("wait_shots_timeout", m_shots, target);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int shots_before;
        #1 rst = 1'b1;
        idleCycles(3);
        checkOutput("reset_state", int'(bus.state), 0);
        checkOutput("reset_hv_en", int'(bus.hv_en), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_shot_cnt", int'(bus.shot_cnt), 0);
        rst = 1'b0;
        idleCycles(2);

        // Nominal shot; settings changed after launch must not matter.
        applyStimulus(1, 0, 0, 8'd2, 8'd1);
        applyStimulus(0, 0, 0, 8'd2, 8'd1);
        waitState(1, 20);
        idleCycles(4);
        applyStimulus(0, 0, 1, 8'd7, 8'd7);
        waitState(4, 200);
        waitState(0, 200);
        checkOutput("nominal_hold_len", last_len[2], 20);
        checkOutput("nominal_fire_len", last_len[3], FIRE_CYC);
        checkOutput("nominal_cool_len", last_len[4], 10);
        checkOutput("nominal_shot_cnt", int'(bus.shot_cnt), 1);

        // Ready timeout, sticky fault, abort recovery.
        applyStimulus(0, 0, 0, 8'd2, 8'd1);
        idleCycles(3);
        applyStimulus(1, 0, 0, 8'd2, 8'd1);
        applyStimulus(0, 0, 0, 8'd2, 8'd1);
        waitState(5, 100);
        checkOutput("timeout_charge_len", last_len[1], 30);
        applyStimulus(1, 0, 0, 8'd2, 8'd1);
        applyStimulus(0, 0, 0, 8'd2, 8'd1);
        idleCycles(2);
        checkOutput("fault_sticky_state", int'(bus.state), 5);
        checkOutput("fault_sticky_flag", int'(bus.fault), 1);
        checkOutput("fault_hv_en", int'(bus.hv_en), 0);
        applyStimulus(0, 1, 0, 8'd2, 8'd1);
        applyStimulus(0, 0, 0, 8'd2, 8'd1);
        checkOutput("fault_abort_state", int'(bus.state), 0);
        checkOutput("fault_abort_flag", int'(bus.fault), 0);

        // Ready drop during HOLD.
        applyStimulus(0, 0, 1, 8'd5, 8'd1);
        idleCycles(3);
        applyStimulus(1, 0, 1, 8'd5, 8'd1);
        applyStimulus(0, 0, 1, 8'd5, 8'd1);
        waitState(2, 20);
        idleCycles(11);
        applyStimulus(0, 0, 0, 8'd5, 8'd1);
        n = 0;
        while (m_state != 5 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drop_to_fault_cycles", n, 3);
        checkOutput("drop_shot_cnt", int'(bus.shot_cnt), 1);
        applyStimulus(0, 1, 1, 8'd0, 8'd0);
        applyStimulus(0, 0, 1, 8'd0, 8'd0);
        idleCycles(3);

        // Zero settings, start held: back-to-back shots with one idle cycle between.
        applyStimulus(1, 0, 1, 8'd0, 8'd0);
        waitShots(4, 200);
        applyStimulus(0, 0, 1, 8'd0, 8'd0);
        checkOutput("zero_hold_len", last_len[2], 1);
        checkOutput("zero_cool_len", last_len[4], 1);
        checkOutput("zero_idle_gap", last_len[0], 1);
        waitState(0, 50);
        idleCycles(2);
        checkOutput("zero_shot_cnt", int'(bus.shot_cnt), 4);

        // Abort on the second FIRE cycle.
        shots_before = m_shots;
        applyStimulus(1, 0, 1, 8'd0, 8'd0);
        applyStimulus(0, 0, 1, 8'd0, 8'd0);
        waitState(3, 50);
        applyStimulus(0, 1, 1, 8'd0, 8'd0);
        applyStimulus(0, 0, 1, 8'd0, 8'd0);
        checkOutput("abort_fire_fire", int'(bus.fire), 0);
        checkOutput("abort_fire_hv_en", int'(bus.hv_en), 0);
        checkOutput("abort_fire_state", int'(bus.state), 0);
        checkOutput("abort_fire_shots", int'(bus.shot_cnt), shots_before);

        // Start and abort together in COOL: abort wins, nothing relaunches.
        applyStimulus(1, 0, 1, 8'd0, 8'd3);
        applyStimulus(0, 0, 1, 8'd0, 8'd3);
        waitState(4, 50);
        idleCycles(2);
        applyStimulus(1, 1, 1, 8'd0, 8'd3);
        applyStimulus(0, 0, 1, 8'd0, 8'd3);
        checkOutput("cool_abort_state", int'(bus.state), 0);
        idleCycles(3);
        checkOutput("cool_abort_stays_idle", int'(bus.state), 0);
        checkOutput("cool_abort_busy", int'(bus.busy), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom % 8) == 0, ($urandom % 60) == 0,
                          (($urandom % 40) == 0) ? ~ready : ready,
                          8'($urandom % 3), 8'($urandom % 3));
        end

        // Counter wrap through the all-ones value.
        applyStimulus(0, 1, 1, 8'd0, 8'd0);
        applyStimulus(0, 0, 1, 8'd0, 8'd0);
        idleCycles(3);
        applyStimulus(1, 0, 1, 8'd0, 8'd0);
        waitShots((1 << CNT_W) - 1, 400);
        waitShots(0, 100);
        checkOutput("wrap_shot_cnt", int'(bus.shot_cnt), 0);
        applyStimulus(0, 0, 1, 8'd0, 8'd0);
        waitState(0, 50);

        // Async reset between clock edges mid-HOLD.
        applyStimulus(0, 0, 1, 8'd5, 8'd0);
        applyStimulus(1, 0, 1, 8'd5, 8'd0);
        applyStimulus(0, 0, 1, 8'd5, 8'd0);
        waitState(2, 20);
        idleCycles(3);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_hv_en", int'(bus.hv_en), 0);
        checkOutput("async_rst_state", int'(bus.state), 0);
        checkOutput("async_rst_shot_cnt", int'(bus.shot_cnt), 0);
        checkOutput("async_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        idleCycles(3);
        checkOutput("post_rst_state", int'(bus.state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
